// File: rtl/bmp180_seq.sv
// BMP180 measurement sequencer: drives a byte-level I2C master through the
// temperature and pressure command/pointer/read phases and returns raw UT/UP.
module bmp180_seq #(
    parameter int CONV_T  = 225000,
    parameter int CONV_P  = 1275000,
    parameter int OSS     = 3,
    parameter int TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic        ready,
    output logic        start,
    output logic        send,
    input  logic        sended,
    output logic        receive,
    input  logic        received,
    output logic [7:0]  datasend,
    input  logic [7:0]  datareceive,
    output logic [15:0] ut,
    output logic [23:0] up,
    output logic        valid,
    output logic        busy,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, WAIT_RDY, WR_BYTE, STOP, CONV, RD_BYTE, DONE} state_t;
    typedef enum logic [2:0] {T_CMD, T_PTR, T_READ, P_CMD, P_PTR, P_READ} phase_t;

    state_t      state, state_n;
    phase_t      phase, phase_n;
    logic [1:0]  idx, idx_n;
    logic [31:0] cnt, cnt_n, wdog, wdog_n;
    logic [23:0] cap, cap_n;
    logic        start_n, send_n, receive_n, valid_n, err_n;
    logic [7:0]  datasend_n;
    logic [15:0] ut_n;
    logic [23:0] up_n;

    logic [7:0]  wr_byte;
    logic [1:0]  wr_last, rd_last;
    logic [31:0] conv_last;
    logic        read_phase, watched;

    assign busy = (state != IDLE);

    // Byte table for the current phase
    always_comb begin
        wr_byte = 8'hEE;
        wr_last = 2'd1;
        rd_last = 2'd1;
        case (phase)
            T_CMD, P_CMD: begin
                wr_last = 2'd2;
                case (idx)
                    2'd0:    wr_byte = 8'hEE;
                    2'd1:    wr_byte = 8'hF4;
                    default: wr_byte = (phase == T_CMD) ? 8'h2E : {2'(OSS), 6'h34};
                endcase
            end
            T_PTR, P_PTR: wr_byte = (idx == 2'd0) ? 8'hEE : 8'hF6;
            T_READ: begin
                wr_byte = 8'hEF;
                wr_last = 2'd0;
            end
            P_READ: begin
                wr_byte = 8'hEF;
                wr_last = 2'd0;
                rd_last = 2'd2;
            end
            default: ;
        endcase
    end

    assign read_phase = (phase == T_READ) || (phase == P_READ);
    assign conv_last  = (phase == T_CMD) ? 32'(CONV_T - 1) : 32'(CONV_P - 1);
    assign watched    = (state == WAIT_RDY) || (state == WR_BYTE) ||
                        (state == RD_BYTE)  || (state == STOP);

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        idx_n      = idx;
        cnt_n      = cnt;
        cap_n      = cap;
        start_n    = start;
        send_n     = send;
        receive_n  = receive;
        datasend_n = datasend;
        valid_n    = 1'b0;
        err_n      = err;
        ut_n       = ut;
        up_n       = up;
        wdog_n     = watched ? wdog + 32'd1 : '0;

        case (state)
            IDLE: if (trigger) begin
                err_n   = 1'b0;
                phase_n = T_CMD;
                state_n = WAIT_RDY;
            end
            WAIT_RDY: if (ready) begin
                start_n = 1'b1;
                idx_n   = '0;
                state_n = WR_BYTE;
            end
            WR_BYTE: begin
                if (!send) begin
                    send_n     = 1'b1;
                    datasend_n = wr_byte;
                end else if (sended) begin
                    send_n = 1'b0;
                    wdog_n = '0;
                    if (idx == wr_last) begin
                        idx_n = '0;
                        if (read_phase) begin
                            state_n = RD_BYTE;
                        end else begin
                            start_n = 1'b0;
                            state_n = STOP;
                        end
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                end
            end
            RD_BYTE: begin
                if (!receive) begin
                    receive_n = 1'b1;
                end else if (received) begin
                    receive_n = 1'b0;
                    wdog_n    = '0;
                    cap_n     = {cap[15:0], datareceive};
                    if (idx == rd_last) begin
                        idx_n   = '0;
                        start_n = 1'b0;
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                end
            end
            STOP: if (ready) begin
                case (phase)
                    T_CMD, P_CMD: begin
                        cnt_n   = '0;
                        state_n = CONV;
                    end
                    T_PTR: begin
                        phase_n = T_READ;
                        state_n = WAIT_RDY;
                    end
                    T_READ: begin
                        ut_n    = cap[15:0];
                        phase_n = P_CMD;
                        state_n = WAIT_RDY;
                    end
                    P_PTR: begin
                        phase_n = P_READ;
                        state_n = WAIT_RDY;
                    end
                    default: state_n = DONE;
                endcase
            end
            CONV: begin
                if (cnt == conv_last) begin
                    cnt_n   = '0;
                    phase_n = (phase == T_CMD) ? T_PTR : P_PTR;
                    state_n = WAIT_RDY;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            DONE: begin
                up_n    = cap;
                valid_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (state_n != state)
            wdog_n = '0;

        // Watchdog overrides whatever the handshake logic decided this cycle
        if (watched && wdog == 32'(TIMEOUT - 1)) begin
            state_n   = IDLE;
            start_n   = 1'b0;
            send_n    = 1'b0;
            receive_n = 1'b0;
            valid_n   = 1'b0;
            err_n     = 1'b1;
            ut_n      = ut;
            wdog_n    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            phase    <= T_CMD;
            idx      <= '0;
            cnt      <= '0;
            wdog     <= '0;
            cap      <= '0;
            start    <= 1'b0;
            send     <= 1'b0;
            receive  <= 1'b0;
            datasend <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
            ut       <= '0;
            up       <= '0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            idx      <= idx_n;
            cnt      <= cnt_n;
            wdog     <= wdog_n;
            cap      <= cap_n;
            start    <= start_n;
            send     <= send_n;
            receive  <= receive_n;
            datasend <= datasend_n;
            valid    <= valid_n;
            err      <= err_n;
            ut       <= ut_n;
            up       <= up_n;
        end
    end
endmodule

// File: tb/tb_bmp180_seq.sv
// Directed bench for bmp180_seq with a simple byte-level I2C master model.
module tb_bmp180_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        trigger = 1'b0;
    logic        ready;
    logic        start, send, receive, valid, busy, err;
    logic        sended = 1'b0, received = 1'b0;
    logic [7:0]  datasend;
    logic [7:0]  datareceive = 8'h00;
    logic [15:0] ut;
    logic [23:0] up;

    logic        ready_en = 1'b1;
    logic        drop_f4 = 1'b0;
    logic [7:0]  rx_data [5];
    int          rx_idx = 0;
    logic [7:0]  sent_log [$];
    int          scnt = 0, rcnt = 0;
    int          vcount = 0, viol = 0, cyc = 0;
    int          t_fall = -1, conv_gap = 0, conv_neg = 0;
    bit          spur_done = 1'b0, prev_start = 1'b0;
    int          checks = 0, errors = 0;

    assign ready = ready_en && !start;

    bmp180_seq #(.CONV_T(10), .CONV_P(20), .OSS(3), .TIMEOUT(50)) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .ready(ready),
        .start(start), .send(send), .sended(sended), .receive(receive),
        .received(received), .datasend(datasend), .datareceive(datareceive),
        .ut(ut), .up(up), .valid(valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // I2C master model: acks every request on its 3rd cycle
    always @(negedge clk) begin
        cyc++;
        sended   = 1'b0;
        received = 1'b0;
        if (!busy) rx_idx = 0;
        if (!reset) begin
            scnt = 0;
            rcnt = 0;
        end else begin
            if (send && !(drop_f4 && datasend == 8'hF4)) begin
                scnt++;
                if (scnt == 3) begin
                    sended = 1'b1;
                    sent_log.push_back(datasend);
                    scnt = 0;
                end
            end else scnt = 0;
            if (receive) begin
                rcnt++;
                if (rcnt == 3) begin
                    received    = 1'b1;
                    datareceive = (rx_idx < 5) ? rx_data[rx_idx] : 8'h00;
                    rx_idx++;
                    rcnt = 0;
                end
            end else rcnt = 0;
            if (busy && !start && sent_log.size() > 0 && sent_log[$] == 8'h2E) conv_neg++;
            else conv_neg = 0;
            if (!spur_done && conv_neg == 4) begin
                received    = 1'b1;
                datareceive = 8'hAA;
                spur_done   = 1'b1;
            end
        end
        if (prev_start && !start && sent_log.size() > 0 && sent_log[$] == 8'h2E) t_fall = cyc;
        if (!prev_start && start && t_fall >= 0) begin
            conv_gap = cyc - t_fall;
            t_fall   = -1;
        end
        prev_start = start;
        if (valid) vcount++;
        if ((send && receive) || ((send || receive) && !start)) viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_trigger;
        @(negedge clk) trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int  v0 = vcount;
        bit  ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (vcount > v0) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic load_rx(input logic [7:0] b0, b1, b2, b3, b4);
        rx_data[0] = b0; rx_data[1] = b1; rx_data[2] = b2; rx_data[3] = b3; rx_data[4] = b4;
    endtask

    task automatic check_log(input string tag, input int base);
        logic [7:0] exp_bytes [12] = '{8'hEE, 8'hF4, 8'h2E, 8'hEE, 8'hF6, 8'hEF,
                                       8'hEE, 8'hF4, 8'hF4, 8'hEE, 8'hF6, 8'hEF};
        check({tag, "_len"}, 32'(sent_log.size() - base), 32'd12);
        for (int i = 0; i < 12; i++)
            if (base + i < sent_log.size())
                check($sformatf("%s_b%0d", tag, i), 32'(sent_log[base + i]), 32'(exp_bytes[i]));
    endtask

    initial begin
        int base, v0, n;
        bit ok;
        load_rx(8'h6C, 8'hFA, 8'h5D, 8'h23, 8'h00);
        repeat (3) @(negedge clk);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_datasend", 32'(datasend), 32'd0);
        check("rst_ut", 32'(ut), 32'd0);
        check("rst_up", 32'(up), 32'd0);
        @(negedge clk) reset = 1'b1;

        // Nominal measurement, with a spurious received pulse during conversion
        base = sent_log.size();
        v0 = vcount;
        pulse_trigger();
        wait_valid("nom_valid");
        repeat (10) @(negedge clk);
        check_log("nom", base);
        check("nom_ut", 32'(ut), 32'h6CFA);
        check("nom_up", 32'(up), 32'h5D2300);
        check("nom_vcount", 32'(vcount - v0), 32'd1);
        check("nom_busy", 32'(busy), 32'd0);
        check("conv_gap_ge", 32'(conv_gap >= 10), 32'd1);
        check("spur_injected", 32'(spur_done), 32'd1);

        // Ack never comes for 0xF4
        drop_f4 = 1'b1;
        v0 = vcount;
        load_rx(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        pulse_trigger();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (send && datasend == 8'hF4) begin
                ok = 1'b1;
                break;
            end
        end
        check("to_saw_f4", 32'(ok), 32'd1);
        n = 0;
        while (!err && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("to_latency", 32'(n <= 51), 32'd1);
        check("to_err", 32'(err), 32'd1);
        check("to_start", 32'(start), 32'd0);
        check("to_send", 32'(send), 32'd0);
        check("to_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        check("to_novalid", 32'(vcount - v0), 32'd0);
        check("to_ut", 32'(ut), 32'h6CFA);
        check("to_up", 32'(up), 32'h5D2300);
        drop_f4 = 1'b0;

        // ready held low, then a re-trigger while busy
        ready_en = 1'b0;
        load_rx(8'h12, 8'h34, 8'hAB, 8'hCD, 8'hEF);
        base = sent_log.size();
        v0 = vcount;
        pulse_trigger();
        check("rl_err_clr", 32'(err), 32'd0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (start) n++;
        end
        check("rl_start_low", 32'(n), 32'd0);
        check("rl_busy", 32'(busy), 32'd1);
        ready_en = 1'b1;
        repeat (8) @(negedge clk);
        pulse_trigger();
        wait_valid("rl_valid");
        repeat (10) @(negedge clk);
        check_log("rl", base);
        check("rl_ut", 32'(ut), 32'h1234);
        check("rl_up", 32'(up), 32'hABCDEF);
        check("rl_vcount", 32'(vcount - v0), 32'd1);

        // Reset during the pressure read
        load_rx(8'h6C, 8'hFA, 8'h5D, 8'h23, 8'h00);
        v0 = vcount;
        pulse_trigger();
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (receive && rx_idx >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        check("mr_reached", 32'(ok), 32'd1);
        reset = 1'b0;
        #1;
        check("mr_start", 32'(start), 32'd0);
        check("mr_receive", 32'(receive), 32'd0);
        check("mr_send", 32'(send), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_valid", 32'(valid), 32'd0);
        check("mr_datasend", 32'(datasend), 32'd0);
        check("mr_ut", 32'(ut), 32'd0);
        check("mr_up", 32'(up), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check("mr_novalid", 32'(vcount - v0), 32'd0);

        base = sent_log.size();
        pulse_trigger();
        wait_valid("mr2_valid");
        check_log("mr2", base);
        check("mr2_ut", 32'(ut), 32'h6CFA);
        check("mr2_up", 32'(up), 32'h5D2300);
        check("protocol_viol", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end
endmodule
